// File: rtl/affine_pipe.sv
// Pipelined y = a*scale + offset with optional running accumulation; AFFINE_PIPE_SAT_EN selects saturation (adds out_sat).
// Latency 2 cycles at 1 sample/cycle; the whole pipe stalls while out_valid && !out_ready.
module affine_pipe #(
    parameter int WIDTH     = 4,
    parameter int OUT_WIDTH = 6,
    parameter int SCALE     = 4,
    parameter int OFFSET    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_mode,
    input  logic                 cfg_we,
    input  logic [WIDTH-1:0]     cfg_scale,
    input  logic [OUT_WIDTH-1:0] cfg_offset,
    input  logic                 acc_clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data
`ifdef AFFINE_PIPE_SAT_EN
    ,
    output logic                 out_sat
`endif
);

    localparam int PW = 2 * WIDTH;
    localparam int TW = (PW + 1 > OUT_WIDTH + 1) ? PW + 1 : OUT_WIDTH + 1;

    logic [WIDTH-1:0]     scale_r;
    logic [OUT_WIDTH-1:0] offset_r;
    logic [OUT_WIDTH-1:0] acc;
    logic                 s1_valid;
    logic                 s1_mode;
    logic [PW-1:0]        s1_prod;
    logic [OUT_WIDTH-1:0] s1_off;
    logic                 advance;
    logic                 acc_xfer;
    logic [OUT_WIDTH-1:0] acc_base;
    logic [OUT_WIDTH-1:0] affine_res;
    logic [OUT_WIDTH-1:0] accum_res;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !reset;
    assign acc_xfer = advance && s1_valid && s1_mode;
    // A clear coinciding with an accumulate transfer zeroes the base before the add.
    assign acc_base = acc_clear ? '0 : acc;

`ifdef AFFINE_PIPE_SAT_EN
    localparam logic [OUT_WIDTH-1:0] MAXV = '1;

    logic [TW-1:0] term;
    logic [TW:0]   sum;
    logic          aff_clamp;
    logic          acc_clamp;

    always_comb begin
        term       = TW'(s1_prod) + TW'(s1_off);
        sum        = (TW + 1)'(acc_base) + (TW + 1)'(term);
        aff_clamp  = term > TW'(MAXV);
        acc_clamp  = sum > (TW + 1)'(MAXV);
        affine_res = aff_clamp ? MAXV : term[OUT_WIDTH-1:0];
        accum_res  = acc_clamp ? MAXV : sum[OUT_WIDTH-1:0];
    end
`else
    logic [OUT_WIDTH-1:0] term;

    always_comb begin
        term       = OUT_WIDTH'(s1_prod) + s1_off;
        affine_res = term;
        accum_res  = acc_base + term;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            scale_r   <= WIDTH'(SCALE);
            offset_r  <= OUT_WIDTH'(OFFSET);
            acc       <= '0;
            s1_valid  <= 1'b0;
            s1_mode   <= 1'b0;
            s1_prod   <= '0;
            s1_off    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef AFFINE_PIPE_SAT_EN
            out_sat   <= 1'b0;
`endif
        end else begin
            if (cfg_we) begin
                scale_r  <= cfg_scale;
                offset_r <= cfg_offset;
            end
            if (advance) begin
                s1_valid  <= in_valid;
                out_valid <= s1_valid;
                if (in_valid) begin
                    s1_prod <= PW'(in_data) * PW'(scale_r);
                    s1_off  <= offset_r;
                    s1_mode <= in_mode;
                end
                if (s1_valid) begin
                    out_data <= s1_mode ? accum_res : affine_res;
`ifdef AFFINE_PIPE_SAT_EN
                    out_sat  <= s1_mode ? acc_clamp : aff_clamp;
`endif
                end
            end
            if (acc_xfer) begin
                acc <= accum_res;
            end else if (acc_clear) begin
                acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_affine_pipe.sv
// Directed bench for affine_pipe: default instance plus a WIDTH=8/OUT_WIDTH=10 instance.
module tb_affine_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, in_mode, cfg_we, acc_clear, out_valid, out_ready;
    logic [3:0] in_data, cfg_scale;
    logic [5:0] cfg_offset, out_data;
    logic       w_in_valid, w_in_ready, w_in_mode, w_out_valid;
    logic [7:0] w_in_data;
    logic [9:0] w_out_data;
`ifdef AFFINE_PIPE_SAT_EN
    logic       out_sat, w_out_sat;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    affine_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .cfg_we(cfg_we), .cfg_scale(cfg_scale),
        .cfg_offset(cfg_offset), .acc_clear(acc_clear), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
`ifdef AFFINE_PIPE_SAT_EN
        , .out_sat(out_sat)
`endif
    );

    affine_pipe #(.WIDTH(8), .OUT_WIDTH(10), .SCALE(3), .OFFSET(1)) dut_w (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .in_mode(w_in_mode), .cfg_we(1'b0), .cfg_scale(8'd0),
        .cfg_offset(10'd0), .acc_clear(1'b0), .out_valid(w_out_valid),
        .out_ready(1'b1), .out_data(w_out_data)
`ifdef AFFINE_PIPE_SAT_EN
        , .out_sat(w_out_sat)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid = 0; in_data = 0; in_mode = 0; cfg_we = 0;
        cfg_scale = 0; cfg_offset = 0; acc_clear = 0; out_ready = 1;
        w_in_valid = 0; w_in_data = 0; w_in_mode = 0;
    endtask

    task automatic send(input logic [3:0] a, input logic m);
        in_valid = 1; in_data = a; in_mode = m;
        tick;
        in_valid = 0;
    endtask

    // Returns X on timeout so the caller's comparison fails.
    task automatic wait_out(output logic [5:0] d);
        bit done = 0;
        d = 'x;
        for (int i = 0; i < 20 && !done; i++) begin
            if (out_valid) begin
                d = out_data;
                done = 1;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        idle_inputs;
        reset = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        tick; tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 6'd0) begin failures++; $display("FAIL rst_out_data got=%0d exp=0", out_data); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready_held got=%b exp=0", in_ready); end
        checks++; if (w_out_valid !== 1'b0 || w_out_data !== 10'd0) begin failures++; $display("FAIL rst_wide got=%b/%0d exp=0/0", w_out_valid, w_out_data); end
`ifdef AFFINE_PIPE_SAT_EN
        checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL rst_out_sat got=%b exp=0", out_sat); end
`endif
        reset = 0;
        in_valid = 1; in_data = 5; in_mode = 0;
        tick;
        in_valid = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_early got=%b exp=0", out_valid); end
        tick;
        checks++; if (out_valid !== 1'b1 || out_data !== 6'd23) begin failures++; $display("FAIL lat_2cyc got=%b/%0d exp=1/23", out_valid, out_data); end
        tick;
    endtask

    task automatic test_cfg_timing;
        in_valid = 1; in_data = 15; in_mode = 0;
        cfg_we = 1; cfg_scale = 5; cfg_offset = 3;
        tick;
        cfg_we = 0;
        tick;
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || out_data !== 6'd63) begin failures++; $display("FAIL cfg_old got=%b/%0d exp=1/63", out_valid, out_data); end
`ifdef AFFINE_PIPE_SAT_EN
        checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL cfg_old_sat got=%b exp=0", out_sat); end
`endif
        tick;
`ifdef AFFINE_PIPE_SAT_EN
        checks++; if (out_valid !== 1'b1 || out_data !== 6'd63) begin failures++; $display("FAIL cfg_new got=%b/%0d exp=1/63", out_valid, out_data); end
        checks++; if (out_sat !== 1'b1) begin failures++; $display("FAIL cfg_new_sat got=%b exp=1", out_sat); end
`else
        checks++; if (out_valid !== 1'b1 || out_data !== 6'd14) begin failures++; $display("FAIL cfg_new got=%b/%0d exp=1/14", out_valid, out_data); end
`endif
        tick;
        cfg_we = 1; cfg_scale = 4; cfg_offset = 3;
        tick;
        cfg_we = 0;
    endtask

    task automatic test_accumulate;
        logic [5:0] d;
        in_mode = 1; in_valid = 1; in_data = 1;
        tick;
        in_data = 2;
        tick;
        checks++; if (out_valid !== 1'b1 || out_data !== 6'd7) begin failures++; $display("FAIL acc_1 got=%b/%0d exp=1/7", out_valid, out_data); end
        in_data = 3;
        tick;
        checks++; if (out_valid !== 1'b1 || out_data !== 6'd18) begin failures++; $display("FAIL acc_2 got=%b/%0d exp=1/18", out_valid, out_data); end
        in_valid = 0;
        tick;
        checks++; if (out_valid !== 1'b1 || out_data !== 6'd33) begin failures++; $display("FAIL acc_3 got=%b/%0d exp=1/33", out_valid, out_data); end
        tick;
        send(4'd2, 1'b1);
        acc_clear = 1;
        tick;
        acc_clear = 0;
        checks++; if (out_valid !== 1'b1 || out_data !== 6'd11) begin failures++; $display("FAIL acc_clear_xfer got=%b/%0d exp=1/11", out_valid, out_data); end
        tick;
        acc_clear = 1;
        tick;
        acc_clear = 0;
        send(4'd0, 1'b1);
        wait_out(d);
        checks++; if (d !== 6'd3) begin failures++; $display("FAIL acc_clear_alone got=%0d exp=3", d); end
    endtask

    task automatic test_back_to_back;
        logic [5:0] got[$];
        logic [5:0] prev_d = 0;
        logic [5:0] v;
        bit         prev_stall = 0;
        int         sent = 0;
        in_mode = 0;
        for (int c = 0; c < 40 && got.size() < 8; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (sent < 8);
            in_data   = sent[3:0];
            #1;
            checks++; if (in_ready !== !(out_valid && !out_ready)) begin failures++; $display("FAIL b2b_in_ready c=%0d got=%b ov=%b or=%b", c, in_ready, out_valid, out_ready); end
            if (prev_stall) begin
                checks++; if (out_valid !== 1'b1 || out_data !== prev_d) begin failures++; $display("FAIL b2b_hold c=%0d got=%b/%0d exp=1/%0d", c, out_valid, out_data, prev_d); end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            if (out_valid && out_ready) got.push_back(out_data);
            if (in_valid && in_ready) sent++;
            tick;
        end
        in_valid = 0; out_ready = 1;
        checks++; if (got.size() != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            v = (i < got.size()) ? got[i] : 6'bx;
            checks++; if (v !== 6'(4 * i + 3)) begin failures++; $display("FAIL b2b_data i=%0d got=%0d exp=%0d", i, v, 4 * i + 3); end
        end
    endtask

    task automatic test_reset_inflight;
        logic [5:0] d;
        cfg_we = 1; cfg_scale = 7; cfg_offset = 9;
        tick;
        cfg_we = 0;
        in_valid = 1; in_data = 1; in_mode = 1;
        tick;
        in_data = 2;
        tick;
        in_valid = 0;
        reset = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rif_in_ready got=%b exp=0", in_ready); end
        tick;
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rif_no_out i=%0d got=%b exp=0", i, out_valid); end
            tick;
        end
        send(4'd2, 1'b1);
        wait_out(d);
        checks++; if (d !== 6'd11) begin failures++; $display("FAIL rif_restore got=%0d exp=11", d); end
    endtask

    task automatic test_wide;
        w_in_valid = 1; w_in_data = 8'd255; w_in_mode = 0;
        tick;
        w_in_mode = 1;
        tick;
        checks++; if (w_out_valid !== 1'b1 || w_out_data !== 10'd766) begin failures++; $display("FAIL wide_affine got=%b/%0d exp=1/766", w_out_valid, w_out_data); end
        tick;
        w_in_valid = 0;
        checks++; if (w_out_valid !== 1'b1 || w_out_data !== 10'd766) begin failures++; $display("FAIL wide_acc1 got=%b/%0d exp=1/766", w_out_valid, w_out_data); end
        tick;
`ifdef AFFINE_PIPE_SAT_EN
        checks++; if (w_out_valid !== 1'b1 || w_out_data !== 10'd1023) begin failures++; $display("FAIL wide_acc2 got=%b/%0d exp=1/1023", w_out_valid, w_out_data); end
        checks++; if (w_out_sat !== 1'b1) begin failures++; $display("FAIL wide_acc2_sat got=%b exp=1", w_out_sat); end
`else
        checks++; if (w_out_valid !== 1'b1 || w_out_data !== 10'd508) begin failures++; $display("FAIL wide_acc2 got=%b/%0d exp=1/508", w_out_valid, w_out_data); end
`endif
        tick;
        checks++; if (w_out_valid !== 1'b0) begin failures++; $display("FAIL wide_drain got=%b exp=0", w_out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_cfg_timing;
        test_accumulate;
        test_back_to_back;
        test_reset_inflight;
        test_wide;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/affine_pipe.md
Name: affine_pipe

Overview:
- Parametrised, pipelined scale-and-offset unit: y = a*scale + offset, with optional running accumulation.
- Runtime-loadable scale/offset registers reset to parameter defaults, so defaults are set per instance and can be overridden at run time.
- Valid/ready streaming on both sides; a micro benchmark block for the synthesis regression suite that exercises parameter propagation together with registers, handshakes and a small control path.

Parameters:
- WIDTH, 4, input sample width in bits; also the width of cfg_scale.
- OUT_WIDTH, 6, result, accumulator and cfg_offset width in bits.
- SCALE, 4, reset value of the scale register.
- OFFSET, 3, reset value of the offset register.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_mode are valid.
- in_ready  output  1  unit can accept a sample this cycle.
- in_data  input  WIDTH  unsigned sample a.
- in_mode  input  1  0 = affine, 1 = accumulate; travels with the sample.
- cfg_we  input  1  load cfg_scale/cfg_offset this cycle.
- cfg_scale  input  WIDTH  new scale, unsigned.
- cfg_offset  input  OUT_WIDTH  new offset, unsigned.
- acc_clear  input  1  zero the accumulator.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  OUT_WIDTH  result.

Behaviour:
- Reset, synchronous and active-high:
  - All registers load on the next rising clk edge: scale_r=SCALE, offset_r=OFFSET, acc=0, s1_valid=0, out_valid=0, out_data=0.
  - in_ready is 0 during the reset cycle.
  - Reset mid-operation discards in-flight samples with no output.
- Stall rule:
  - advance = !out_valid || out_ready.
  - in_ready = advance (whole-pipe stall); accept = in_valid && in_ready.
- Stage 1, on accept:
  - s1_prod = in_data*scale_r at full 2*WIDTH bits.
  - s1_off = offset_r; s1_mode = in_mode; s1_valid = 1.
  - When advance && !in_valid, s1_valid = 0.
  - While stalled, stage 1 holds.
- Config timing:
  - Scale and offset are snapshotted at acceptance.
  - cfg_we updates scale_r/offset_r at the clock edge.
  - A sample accepted in the same cycle as cfg_we uses the old values; samples accepted later use the new values.
  - In-flight samples are never affected by a config write.
- Stage 2, on advance:
  - out_valid <= s1_valid.
  - If s1_valid: term = s1_prod + s1_off, computed at 2*WIDTH+1 bits or OUT_WIDTH+1 bits, whichever is wider.
  - Affine mode: out_data <= term[OUT_WIDTH-1:0]; acc unchanged.
  - Accumulate mode: acc_next = acc + term, wrapped to OUT_WIDTH; acc <= acc_next; out_data <= acc_next.
- Latency: 2 cycles from accept to out_valid with no stall; throughput 1 sample/cycle.
- Output hold: out_data/out_valid are held while out_valid && !out_ready.
- acc_clear:
  - Alone: acc <= 0.
  - Coincident with an accumulate transfer: acc <= term (clear first, then add); out_data = term.
  - Does not affect affine samples or in-flight stage-1 data.
- Overflow: results wrap modulo 2^OUT_WIDTH without the optional feature.
- No combinational path from in_valid to out_valid; the only combinational paths are out_valid/out_ready -> in_ready.

Optional Feature:
- Macro AFFINE_PIPE_SAT_EN.
- When defined, unsigned saturation applies:
  - Affine result = min(term, 2^OUT_WIDTH-1).
  - Accumulate acc_next = min(acc+term, 2^OUT_WIDTH-1); the accumulator sticks at max until acc_clear.
  - Adds one output, out_sat (1 bit, reset 0), set with out_valid when clamping occurred and held with out_data.
- When undefined, results wrap and out_sat does not exist.

Test Plan:
- Reset, then a=5, mode 0 -> out_data=23 exactly 2 cycles after accept; all outputs 0 during reset.
- cfg_we scale=5, offset=3 in the same cycle a=15 is accepted -> out=63 (old values). Next sample a=15 -> 78 mod 64 = 14; with AFFINE_PIPE_SAT_EN -> 63 with out_sat=1.
- Stream a=1,2,3 in mode 1 from acc=0 -> outputs 7, 18, 33. Then acc_clear alongside the transfer of a=2 -> output 11.
- Back-to-back a=0..7 with out_ready low for cycles 3-5:
  - Outputs 3,7,11,...,31 in order, no loss or duplication.
  - in_ready low exactly while out_valid && !out_ready; out_data stable during the stall.
- Assert reset with two samples in flight -> no out_valid afterwards; a mode-1 sample after reset starts from acc=0 with scale 4 and offset 3 restored.
- Instance with WIDTH=8, OUT_WIDTH=10, SCALE=3, OFFSET=1: a=255 -> 766; mode 1 a=255 twice -> 766 then 508 (1532 mod 1024), saturating to 1023 with the macro defined.
